// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch front end: instruction packet, fetch FSM states, block geometry defaults.
package fetch_stage_pkg;

   localparam int DEF_FETCH_WIDTH = 4;
   localparam int INST_BUFF_DEPTH = 8;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] PC;
      logic [31:0] NPC;
      logic        valid;
   } INST_PACKET;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } FETCH_STATE;

   // Clears the word offset and byte offset bits of a PC for a block of fw words.
   function automatic logic [31:0] block_base(input logic [31:0] pc, input int fw);
      logic [31:0] mask;
      mask = 32'(fw * 4) - 32'd1;
      return pc & ~mask;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Redirect, I-cache request/response and instruction-buffer delivery bundle of the fetch stage.
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int DEPTH       = INST_BUFF_DEPTH
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                     redirect_valid;
   logic [31:0]              redirect_pc;
   logic                     icache_req_valid;
   logic [31:0]              icache_req_addr;
   logic                     icache_req_ready;
   logic                     icache_resp_valid;
   logic [FETCH_WIDTH*32-1:0] icache_resp_data;
   logic [CW-1:0]            open_entries;
   INST_PACKET               out_insts [DEPTH];
   logic [CW-1:0]            num_accept;

   modport master (
      input  redirect_valid, redirect_pc, icache_req_ready,
             icache_resp_valid, icache_resp_data, open_entries,
      output icache_req_valid, icache_req_addr, out_insts, num_accept
   );

   modport slave (
      output redirect_valid, redirect_pc, icache_req_ready,
             icache_resp_valid, icache_resp_data, open_entries,
      input  icache_req_valid, icache_req_addr, out_insts, num_accept
   );

endinterface

// File: rtl/fetch_stage_unpack.sv
// Combinational: splits a fetch block into packets starting at the PC's word offset; zero latency.
module fetch_stage_unpack
   import fetch_stage_pkg::*;
#(
   parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int DEPTH       = INST_BUFF_DEPTH
) (
   input  logic [FETCH_WIDTH*32-1:0]   data_i,
   input  logic [31:0]                 pc_i,
   input  logic                        valid_i,
   output INST_PACKET                  insts_o [DEPTH],
   output logic [$clog2(DEPTH+1)-1:0]  cnt_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

   logic [OW-1:0] off;
   logic [31:0]   words [FETCH_WIDTH];

   // A single-word block has no offset field; the selected bit is ignored.
   assign off   = (FETCH_WIDTH > 1) ? pc_i[OW+1:2] : '0;
   assign cnt_o = CW'(FETCH_WIDTH) - CW'(off);

   always_comb begin
      for (int w = 0; w < FETCH_WIDTH; w++) begin
         words[w] = data_i[w*32 +: 32];
      end
   end

   always_comb begin
      logic [OW-1:0] idx;
      idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         insts_o[k] = '0;
      end
      if (valid_i) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (k < int'(cnt_o)) begin
               idx              = off + OW'(k);
               insts_o[k].inst  = words[idx];
               insts_o[k].PC    = pc_i + 32'(4 * k);
               insts_o[k].NPC   = pc_i + 32'(4 * k + 4);
               insts_o[k].valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC + one-outstanding I-cache requester; delivers a block the cycle its response lands (or from hold).
// Delivery is all-or-nothing, stalled in HOLD until open_entries covers the block; redirect squashes everything.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int          FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int          DEPTH       = INST_BUFF_DEPTH,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input logic           clock_i,
   input logic           reset_ni,
   fetch_stage_if.master bus
);
   localparam int          CW        = $clog2(DEPTH + 1);
   localparam logic [31:0] BLK_BYTES = 32'(FETCH_WIDTH * 4);

   FETCH_STATE                state_q, state_d;
   logic [31:0]               pc_q, pc_d;
   logic                      drop_q, drop_d;
   logic                      hold_vld_q, hold_vld_d;
   logic [FETCH_WIDTH*32-1:0] hold_q, hold_d;

   logic [FETCH_WIDTH*32-1:0] blk_data;
   logic [CW-1:0]             cnt;
   logic                      room;
   logic                      deliver;
   INST_PACKET                pkts [DEPTH];

   // Same unpacker serves both the direct response path and the hold path.
   assign blk_data = (state_q == HOLD) ? hold_q : bus.icache_resp_data;
   assign room     = bus.open_entries >= cnt;
   assign deliver  = !bus.redirect_valid && room &&
                     ((state_q == WAIT && bus.icache_resp_valid && !drop_q) ||
                      (state_q == HOLD && hold_vld_q));

   fetch_stage_unpack #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .DEPTH       (DEPTH)
   ) u_unpack (
      .data_i  (blk_data),
      .pc_i    (pc_q),
      .valid_i (deliver),
      .insts_o (pkts),
      .cnt_o   (cnt)
   );

   assign bus.icache_req_valid = reset_ni && (state_q == FETCH);
   assign bus.icache_req_addr  = block_base(pc_q, FETCH_WIDTH);
   assign bus.num_accept       = deliver ? cnt : '0;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         bus.out_insts[k] = pkts[k];
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         hold_vld_q <= hold_vld_d;
         hold_q     <= hold_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;

      if (bus.redirect_valid) begin
         pc_d       = bus.redirect_pc;
         hold_vld_d = 1'b0;
         unique case (state_q)
            FETCH: begin
               // A request accepted this cycle is already in flight; its response must be eaten.
               if (bus.icache_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = WAIT;
               end else begin
                  state_d = FETCH;
               end
            end
            WAIT: begin
               if (bus.icache_resp_valid) begin
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end else begin
                  drop_d  = 1'b1;
                  state_d = WAIT;
               end
            end
            HOLD:    state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            FETCH: begin
               if (bus.icache_req_ready) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.icache_resp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = FETCH;
                  end else if (room) begin
                     pc_d    = block_base(pc_q, FETCH_WIDTH) + BLK_BYTES;
                     state_d = FETCH;
                  end else begin
                     hold_d     = bus.icache_resp_data;
                     hold_vld_d = 1'b1;
                     state_d    = HOLD;
                  end
               end
            end
            HOLD: begin
               if (room) begin
                  pc_d       = block_base(pc_q, FETCH_WIDTH) + BLK_BYTES;
                  hold_vld_d = 1'b0;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: FETCH_WIDTH=4, DEPTH=8, RESET_PC=0, single-cycle cache driven by hand.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clock_i;
   logic reset_ni;
   int   checks;
   int   errors;

   fetch_stage_if #(.FETCH_WIDTH(4), .DEPTH(8)) bus ();

   fetch_stage #(
      .FETCH_WIDTH (4),
      .DEPTH       (8),
      .RESET_PC    (32'h0)
   ) dut (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_pkt(input string tag, input INST_PACKET obs, input INST_PACKET exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] blk(input logic [31:0] base);
      return {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endfunction

   // Checks the request for exp_addr and lets the cache accept it; DUT is in WAIT afterwards.
   task automatic issue(input logic [31:0] exp_addr);
      settle();
      chk("req_valid", 32'(bus.icache_req_valid), 32'd1);
      chk("req_addr", bus.icache_req_addr, exp_addr);
      bus.icache_req_ready = 1'b1;
      tick();
      bus.icache_req_ready = 1'b0;
   endtask

   task automatic resp_on(input logic [31:0] base);
      bus.icache_resp_valid = 1'b1;
      bus.icache_resp_data  = blk(base);
      settle();
   endtask

   initial begin
      INST_PACKET zero_pkt;
      zero_pkt  = '0;
      checks    = 0;
      errors    = 0;
      reset_ni  = 1'b0;
      bus.redirect_valid    = 1'b0;
      bus.redirect_pc       = 32'h0;
      bus.icache_req_ready  = 1'b0;
      bus.icache_resp_valid = 1'b0;
      bus.icache_resp_data  = '0;
      bus.open_entries      = 4'd8;
      #2;
      chk("rst_req_valid", 32'(bus.icache_req_valid), 32'd0);
      chk("rst_num_accept", 32'(bus.num_accept), 32'd0);
      chk_pkt("rst_slot0", bus.out_insts[0], zero_pkt);

      // Sequential blocks from reset
      tick();
      reset_ni = 1'b1;
      issue(32'h0);
      chk("wait_no_req", 32'(bus.icache_req_valid), 32'd0);
      resp_on(32'hA000_0000);
      chk("b0_num", 32'(bus.num_accept), 32'd4);
      chk("b0_pc0", bus.out_insts[0].PC, 32'h0);
      chk("b0_npc0", bus.out_insts[0].NPC, 32'h4);
      chk("b0_pc3", bus.out_insts[3].PC, 32'hC);
      chk("b0_inst3", bus.out_insts[3].inst, 32'hA000_0003);
      chk("b0_valid3", 32'(bus.out_insts[3].valid), 32'd1);
      chk_pkt("b0_slot4", bus.out_insts[4], zero_pkt);
      tick();
      bus.icache_resp_valid = 1'b0;
      issue(32'h10);
      resp_on(32'hB000_0000);
      chk("b1_num", 32'(bus.num_accept), 32'd4);
      chk("b1_pc0", bus.out_insts[0].PC, 32'h10);
      chk("b1_pc3", bus.out_insts[3].PC, 32'h1C);
      chk("b1_inst0", bus.out_insts[0].inst, 32'hB000_0000);
      tick();
      bus.icache_resp_valid = 1'b0;

      // Redirect into the middle of a block
      settle();
      chk("b2_addr", bus.icache_req_addr, 32'h20);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h108;
      settle();
      chk("redir_num", 32'(bus.num_accept), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      issue(32'h100);
      resp_on(32'hC000_0000);
      chk("mid_num", 32'(bus.num_accept), 32'd2);
      chk("mid_pc0", bus.out_insts[0].PC, 32'h108);
      chk("mid_npc0", bus.out_insts[0].NPC, 32'h10C);
      chk("mid_inst0", bus.out_insts[0].inst, 32'hC000_0002);
      chk("mid_pc1", bus.out_insts[1].PC, 32'h10C);
      chk("mid_npc1", bus.out_insts[1].NPC, 32'h110);
      chk("mid_inst1", bus.out_insts[1].inst, 32'hC000_0003);
      chk_pkt("mid_slot2", bus.out_insts[2], zero_pkt);
      tick();
      bus.icache_resp_valid = 1'b0;

      // Not enough room: hold, then release all at once
      issue(32'h110);
      bus.open_entries = 4'd2;
      resp_on(32'hD000_0000);
      chk("hold_num_resp", 32'(bus.num_accept), 32'd0);
      tick();
      bus.icache_resp_valid = 1'b0;
      settle();
      chk("hold_num", 32'(bus.num_accept), 32'd0);
      chk("hold_no_req", 32'(bus.icache_req_valid), 32'd0);
      bus.open_entries = 4'd4;
      settle();
      chk("hold_rel_num", 32'(bus.num_accept), 32'd4);
      chk("hold_rel_pc0", bus.out_insts[0].PC, 32'h110);
      chk("hold_rel_inst2", bus.out_insts[2].inst, 32'hD000_0002);
      tick();
      bus.open_entries = 4'd8;

      // Redirect while waiting: the late response is dropped
      issue(32'h120);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      settle();
      chk("wredir_num", 32'(bus.num_accept), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      settle();
      chk("drop_no_req", 32'(bus.icache_req_valid), 32'd0);
      tick();
      tick();
      resp_on(32'hE000_0000);
      chk("drop_num", 32'(bus.num_accept), 32'd0);
      tick();
      bus.icache_resp_valid = 1'b0;
      issue(32'h200);

      // Redirect coinciding with the response
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h304;
      resp_on(32'hF000_0000);
      chk("coin_num", 32'(bus.num_accept), 32'd0);
      tick();
      bus.redirect_valid    = 1'b0;
      bus.icache_resp_valid = 1'b0;
      issue(32'h300);
      resp_on(32'h1100_0000);
      chk("coin_blk_num", 32'(bus.num_accept), 32'd3);
      chk("coin_blk_pc0", bus.out_insts[0].PC, 32'h304);
      chk("coin_blk_inst0", bus.out_insts[0].inst, 32'h1100_0001);
      tick();
      bus.icache_resp_valid = 1'b0;

      // PC wrap at 2^32
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      issue(32'hFFFF_FFF0);
      resp_on(32'h2200_0000);
      chk("wrap_num", 32'(bus.num_accept), 32'd1);
      chk("wrap_pc0", bus.out_insts[0].PC, 32'hFFFF_FFFC);
      chk("wrap_npc0", bus.out_insts[0].NPC, 32'h0);
      chk("wrap_inst0", bus.out_insts[0].inst, 32'h2200_0003);
      tick();
      bus.icache_resp_valid = 1'b0;
      issue(32'h0);
      resp_on(32'h3300_0000);
      chk("post_wrap_num", 32'(bus.num_accept), 32'd4);
      tick();
      bus.icache_resp_valid = 1'b0;

      // Reset during HOLD
      issue(32'h10);
      bus.open_entries = 4'd0;
      resp_on(32'h4400_0000);
      tick();
      bus.icache_resp_valid = 1'b0;
      settle();
      chk("rh_hold_num", 32'(bus.num_accept), 32'd0);
      reset_ni         = 1'b0;
      bus.open_entries = 4'd8;
      settle();
      chk("rh_num", 32'(bus.num_accept), 32'd0);
      chk("rh_req_valid", 32'(bus.icache_req_valid), 32'd0);
      chk_pkt("rh_slot0", bus.out_insts[0], zero_pkt);
      tick();
      reset_ni = 1'b1;
      settle();
      chk("rh_req_valid_after", 32'(bus.icache_req_valid), 32'd1);
      chk("rh_addr_after", bus.icache_req_addr, 32'h0);
      resp_on(32'h5500_0000);
      chk("stale_num", 32'(bus.num_accept), 32'd0);
      tick();
      bus.icache_resp_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
